// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, memory-request FSM states and the default
// watchdog limit used by mem_request_unit.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        EXEC,
        DACCESS
    } memreq_state_t;

    localparam int MEMREQ_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/mem_request_unit_if.sv
// Request/response bundle between mem_request_unit (master) and
// memory_control (slave).
interface mem_request_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imemRen;
    logic [ADDR_W-1:0] imemaddr;
    logic              dmmRen;
    logic              dmmWen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic [DATA_W-1:0] imemload;
    logic [DATA_W-1:0] dmmload;
    logic              i_ready;
    logic              d_ready;

    modport master (
        output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore,
        input  imemload, dmmload, i_ready, d_ready
    );

    modport slave (
        input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore,
        output imemload, dmmload, i_ready, d_ready
    );
endinterface

// File: rtl/memreq_watchdog.sv
// Outstanding-request watchdog: cycle counter restarted per request plus a
// sticky error flag. Only instantiated when MEM_REQ_TIMEOUT_EN is defined.
module memreq_watchdog
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEMREQ_TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic start,
    input  logic active,
    input  logic done,
    output logic expire,
    output logic timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // A completing request wins over a same-cycle expiry.
    assign expire      = active && !done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start) begin
                cnt_q <= '0;
            end else if (active) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_request_unit.sv
// Registers datapath fetch/load/store intent into stable memory_control
// requests, one outstanding at a time. Optional watchdog: MEM_REQ_TIMEOUT_EN.
module mem_request_unit
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = MEMREQ_TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              dp_advance,
    input  logic              dp_ren,
    input  logic              dp_wen,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [DATA_W-1:0] dp_rdata,
    output logic              data_done,
    output logic              stall,
    output logic              timeout_err,
    mem_request_unit_if.master mem
);
    memreq_state_t     state_q, state_d;
    logic              imem_ren_q, imem_ren_d;
    logic              dmm_ren_q, dmm_ren_d;
    logic              dmm_wen_q, dmm_wen_d;
    logic [ADDR_W-1:0] imemaddr_q, imemaddr_d;
    logic [ADDR_W-1:0] dmmaddr_q, dmmaddr_d;
    logic [DATA_W-1:0] dmmstore_q, dmmstore_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_vld_q, instr_vld_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              wd_expire;

    always_comb begin
        state_d     = state_q;
        imem_ren_d  = imem_ren_q;
        dmm_ren_d   = dmm_ren_q;
        dmm_wen_d   = dmm_wen_q;
        imemaddr_d  = imemaddr_q;
        dmmaddr_d   = dmmaddr_q;
        dmmstore_d  = dmmstore_q;
        instr_d     = instr_q;
        instr_vld_d = 1'b0;
        rdata_d     = rdata_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                imemaddr_d = pc_in;
                imem_ren_d = 1'b1;
                state_d    = IFETCH;
            end
            IFETCH: begin
                if (mem.i_ready) begin
                    instr_d     = mem.imemload;
                    instr_vld_d = 1'b1;
                    imem_ren_d  = 1'b0;
                    state_d     = EXEC;
                end else if (wd_expire) begin
                    imem_ren_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Data access beats a same-cycle advance; a load+store is a store.
                if (dp_wen) begin
                    dmmaddr_d  = dp_addr;
                    dmmstore_d = dp_wdata;
                    dmm_wen_d  = 1'b1;
                    dmm_ren_d  = 1'b0;
                    state_d    = DACCESS;
                end else if (dp_ren) begin
                    dmmaddr_d = dp_addr;
                    dmm_ren_d = 1'b1;
                    dmm_wen_d = 1'b0;
                    state_d   = DACCESS;
                end else if (dp_advance) begin
                    imemaddr_d = pc_in;
                    imem_ren_d = 1'b1;
                    state_d    = IFETCH;
                end
            end
            DACCESS: begin
                if (mem.d_ready) begin
                    if (dmm_ren_q && !dmm_wen_q) begin
                        rdata_d = mem.dmmload;
                    end
                    done_d    = 1'b1;
                    dmm_ren_d = 1'b0;
                    dmm_wen_d = 1'b0;
                    state_d   = EXEC;
                end else if (wd_expire) begin
                    dmm_ren_d = 1'b0;
                    dmm_wen_d = 1'b0;
                    state_d   = EXEC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            imem_ren_q  <= 1'b0;
            dmm_ren_q   <= 1'b0;
            dmm_wen_q   <= 1'b0;
            imemaddr_q  <= '0;
            dmmaddr_q   <= '0;
            dmmstore_q  <= '0;
            instr_q     <= '0;
            instr_vld_q <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_ren_q  <= imem_ren_d;
            dmm_ren_q   <= dmm_ren_d;
            dmm_wen_q   <= dmm_wen_d;
            imemaddr_q  <= imemaddr_d;
            dmmaddr_q   <= dmmaddr_d;
            dmmstore_q  <= dmmstore_d;
            instr_q     <= instr_d;
            instr_vld_q <= instr_vld_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    logic wd_start, wd_active, wd_done;

    // No direct request-to-request transition exists, so entering a
    // request state from a non-request state marks a new request.
    assign wd_active = (state_q == IFETCH) || (state_q == DACCESS);
    assign wd_start  = ((state_d == IFETCH) || (state_d == DACCESS)) && !wd_active;
    assign wd_done   = ((state_q == IFETCH) && mem.i_ready) ||
                       ((state_q == DACCESS) && mem.d_ready);

    memreq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK        (CLK),
        .nRST       (nRST),
        .start      (wd_start),
        .active     (wd_active),
        .done       (wd_done),
        .expire     (wd_expire),
        .timeout_err(timeout_err)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign mem.imemRen  = imem_ren_q;
    assign mem.imemaddr = imemaddr_q;
    assign mem.dmmRen   = dmm_ren_q;
    assign mem.dmmWen   = dmm_wen_q;
    assign mem.dmmaddr  = dmmaddr_q;
    assign mem.dmmstore = dmmstore_q;

    assign instr_out   = instr_q;
    assign instr_valid = instr_vld_q;
    assign dp_rdata    = rdata_q;
    assign data_done   = done_q;
    assign stall       = imem_ren_q | dmm_ren_q | dmm_wen_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: stimulus queues expected
// instr_valid/data_done results, a negedge monitor pops and compares them.
module tb_mem_request_unit;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 256;
`endif

    logic        CLK;
    logic        nRST;
    logic [31:0] pc_in;
    logic        dp_advance, dp_ren, dp_wen;
    logic [31:0] dp_addr, dp_wdata;
    logic [31:0] instr_out, dp_rdata;
    logic        instr_valid, data_done, stall, timeout_err;

    mem_request_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_request_unit #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .dp_advance(dp_advance),
        .dp_ren(dp_ren), .dp_wen(dp_wen), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .dp_rdata(dp_rdata),
        .data_done(data_done), .stall(stall), .timeout_err(timeout_err),
        .mem(mif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_instr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (nRST) begin
            if (instr_valid) begin
                if (exp_q.size() == 0 || !exp_q[0].is_instr) begin
                    check("unexpected instr_valid", 32'(instr_valid), 32'd0);
                end else begin
                    check("instr_out", instr_out, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (data_done) begin
                if (exp_q.size() == 0 || exp_q[0].is_instr) begin
                    check("unexpected data_done", 32'(data_done), 32'd0);
                end else begin
                    check("dp_rdata", dp_rdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Entered at a negedge with the fetch request already visible.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int wait_cyc);
        int cnt;
        cnt = 0;
        exp_q.push_back('{1'b1, data});
        check("imemaddr", mif.imemaddr, addr);
        for (int i = 0; i < wait_cyc; i++) begin
            if (mif.imemRen && stall && mif.imemaddr == addr) cnt++;
            if (i == wait_cyc - 1) begin
                mif.i_ready  = 1'b1;
                mif.imemload = data;
            end
            @(negedge CLK);
        end
        mif.i_ready  = 1'b0;
        mif.imemload = 32'hBAD0_0BAD;
        check("imemRen cycles", 32'(cnt), 32'(wait_cyc));
        check("stall after fetch", {31'd0, stall | mif.imemRen}, 32'd0);
    endtask

    // Entered at a negedge in EXEC; returns at the negedge showing data_done.
    task automatic data_op(input bit st, input bit both, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wait_cyc,
                           input logic [31:0] load, input logic [31:0] exp_rdata,
                           input bit adv);
        int cnt;
        bit stable;
        cnt    = 0;
        stable = 1'b1;
        dp_addr    = addr;
        dp_wdata   = wdata;
        dp_wen     = st;
        dp_ren     = !st || both;
        dp_advance = adv;
        exp_q.push_back('{1'b0, exp_rdata});
        @(negedge CLK);
        dp_wen   = 1'b0;
        dp_ren   = 1'b0;
        dp_addr  = 32'hFFFF_FFFC;
        dp_wdata = ~wdata;
        for (int i = 0; i < wait_cyc; i++) begin
            if ((st ? mif.dmmWen : mif.dmmRen) && stall) cnt++;
            if (mif.dmmaddr != addr || (st && mif.dmmstore != wdata)) stable = 1'b0;
            if ((st ? mif.dmmRen : mif.dmmWen) || mif.imemRen) stable = 1'b0;
            if (i == wait_cyc - 1) begin
                mif.d_ready = 1'b1;
                mif.dmmload = load;
            end
            @(negedge CLK);
        end
        mif.d_ready = 1'b0;
        mif.dmmload = 32'h0BAD_F00D;
        check(st ? "dmmWen cycles" : "dmmRen cycles", 32'(cnt), 32'(wait_cyc));
        check("dmm addr/data stable", 32'(stable), 32'd1);
        check("dmm request drop", {30'd0, mif.dmmRen, mif.dmmWen}, 32'd0);
    endtask

    initial begin
        int cnt;
        nRST = 1'b0;
        pc_in = '0; dp_advance = 1'b0; dp_ren = 1'b0; dp_wen = 1'b0;
        dp_addr = '0; dp_wdata = '0;
        mif.imemload = '0; mif.dmmload = '0; mif.i_ready = 1'b0; mif.d_ready = 1'b0;
        repeat (2) @(negedge CLK);

        check("reset req lines", {27'd0, mif.imemRen, mif.dmmRen, mif.dmmWen, stall, timeout_err}, 32'd0);
        check("reset pulses", {30'd0, instr_valid, data_done}, 32'd0);
        check("reset instr_out", instr_out, 32'd0);
        check("reset dp_rdata", dp_rdata, 32'd0);
        check("reset addresses", mif.imemaddr | mif.dmmaddr | mif.dmmstore, 32'd0);

        // First fetch after reset, ready on the third request cycle.
        pc_in = 32'h0000_0000;
        nRST  = 1'b1;
        @(negedge CLK);
        fetch(32'h0000_0000, 32'h0010_0093, 3);

        data_op(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        data_op(1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 3, 32'h5555_AAAA, 32'hDEAD_BEEF, 1'b0);
        data_op(1'b1, 1'b1, 32'h0000_0208, 32'hCAFE_F00D, 1, 32'h7777_7777, 32'hDEAD_BEEF, 1'b0);

        // Load and advance together: data first, then the fetch of pc_in.
        pc_in = 32'h0000_0004;
        data_op(1'b0, 1'b0, 32'h0000_010C, 32'h0, 1, 32'h0000_0042, 32'h0000_0042, 1'b1);
        @(negedge CLK);
        dp_advance = 1'b0;
        fetch(32'h0000_0004, 32'h0000_0013, 1);

        // Reset in the middle of a load.
        dp_addr = 32'h0000_0300;
        dp_ren  = 1'b1;
        @(negedge CLK);
        dp_ren = 1'b0;
        check("mid-load dmmRen", 32'(mif.dmmRen), 32'd1);
        nRST = 1'b0;
        #1;
        check("async reset drop", {29'd0, mif.dmmRen, mif.dmmWen, stall}, 32'd0);
        mif.d_ready = 1'b1;
        mif.dmmload = 32'h9999_9999;
        @(negedge CLK);
        mif.d_ready = 1'b0;
        check("no partial result", dp_rdata, 32'd0);
        pc_in = 32'h0000_0040;
        nRST  = 1'b1;
        @(negedge CLK);
        fetch(32'h0000_0040, 32'h0020_0113, 2);

        // Fetch with no ready for 12 cycles.
        pc_in      = 32'h0000_0080;
        dp_advance = 1'b1;
        @(negedge CLK);
        dp_advance = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (mif.imemRen) cnt++;
            @(negedge CLK);
        end
`ifdef MEM_REQ_TIMEOUT_EN
        check("timeout imemRen cycles", 32'(cnt), 32'd8);
        check("timeout_err set", 32'(timeout_err), 32'd1);
        repeat (3) @(negedge CLK);
        check("timeout_err sticky", {30'd0, timeout_err, mif.imemRen}, 32'd2);
`else
        check("long wait imemRen cycles", 32'(cnt), 32'd12);
        check("timeout_err tied low", 32'(timeout_err), 32'd0);
        fetch(32'h0000_0080, 32'h0000_0073, 1);
`endif

        repeat (3) @(negedge CLK);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
